// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC-16 receive sequencer.
// Optional error counter in crc_frame_ctrl is enabled with macro CRC_ERRCNT_EN.
package crc_pkg;

   localparam int unsigned CRC_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_TRL_HI,
      ST_TRL_LO,
      ST_DONE
   } state_e;

   localparam logic [CRC_W-1:0] CRC16_POLY  = 16'h8005;
   localparam logic [CRC_W-1:0] CRC16_INIT  = 16'hFFFF;
   localparam logic [CRC_W-1:0] CRC16_CHECK = 16'hAEE7;

   // One MSB-first shift step of the non-reflected CRC register.
   function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                   input logic             bit_in,
                                                   input logic [CRC_W-1:0] poly);
      logic fb;
      fb = crc[CRC_W-1] ^ bit_in;
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
   endfunction

endpackage

// File: rtl/crc16_bit_engine.sv
// Serial CRC-16 shift register: one message bit per enabled cycle, init wins over en.
module crc16_bit_engine
   import crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY = CRC16_POLY,
   parameter logic [CRC_W-1:0] INIT = CRC16_INIT
) (
   input  logic             clck,
   input  logic             rstn,
   input  logic             init,
   input  logic             en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc
);

   always_ff @(posedge clck or negedge rstn) begin
      if (!rstn) begin
         crc <= INIT;
      end else if (init) begin
         crc <= INIT;
      end else if (en) begin
         crc <= crc16_step(crc, bit_in, POLY);
      end
   end

endmodule

// File: rtl/crc_frame_ctrl.sv
// Receive-side frame sequencer: serialises payload bytes into the CRC engine and checks the trailer.
// Build with CRC_ERRCNT_EN to add the saturating err_cnt output and err_clr input.
module crc_frame_ctrl
   import crc_pkg::*;
#(
   parameter int unsigned      LEN_W = 8,
   parameter logic [CRC_W-1:0] POLY  = CRC16_POLY,
   parameter logic [CRC_W-1:0] INIT  = CRC16_INIT
) (
   input  logic             clck,
   input  logic             rstn,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             busy,
   output logic             done,
   output logic             crc_ok,
   output logic [CRC_W-1:0] crc_out
`ifdef CRC_ERRCNT_EN
   ,
   input  logic             err_clr,
   output logic [15:0]      err_cnt
`endif
);

   state_e             state;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   byte_cnt;
   logic [7:0]         shift_reg;
   logic [7:0]         trl_hi;
   logic [2:0]         bit_cnt;
   logic [CRC_W-1:0]   eng_crc;
   logic               init_c;
   logic               en_c;
   logic               bit_c;
   logic               accept_c;

   assign accept_c = s_valid && s_ready;
   assign init_c   = (state == ST_IDLE) && start;
   assign en_c     = (state == ST_SHIFT);
   assign bit_c    = shift_reg[bit_cnt];

   crc16_bit_engine #(
      .POLY (POLY),
      .INIT (INIT)
   ) u_engine (
      .clck   (clck),
      .rstn   (rstn),
      .init   (init_c),
      .en     (en_c),
      .bit_in (bit_c),
      .crc    (eng_crc)
   );

   // Frame FSM with registered handshake and status outputs.
   always_ff @(posedge clck or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         s_ready   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         crc_ok    <= 1'b0;
         crc_out   <= '0;
         len_q     <= '0;
         byte_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         trl_hi    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  len_q    <= len;
                  byte_cnt <= '0;
                  crc_ok   <= 1'b0;
                  busy     <= 1'b1;
                  s_ready  <= 1'b1;
                  if (len == '0) begin
                     crc_out <= INIT;
                     state   <= ST_TRL_HI;
                  end else begin
                     state   <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (accept_c) begin
                  shift_reg <= s_data;
                  bit_cnt   <= 3'd7;
                  s_ready   <= 1'b0;
                  state     <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bit_cnt <= bit_cnt - 3'd1;
               if (bit_cnt == 3'd0) begin
                  byte_cnt <= byte_cnt + LEN_W'(1);
                  s_ready  <= 1'b1;
                  if (LEN_W'(byte_cnt + LEN_W'(1)) < len_q) begin
                     state <= ST_LOAD;
                  end else begin
                     // Capture includes the final bit the engine absorbs on this same edge.
                     crc_out <= crc16_step(eng_crc, bit_c, POLY);
                     state   <= ST_TRL_HI;
                  end
               end
            end
            ST_TRL_HI: begin
               if (accept_c) begin
                  trl_hi <= s_data;
                  state  <= ST_TRL_LO;
               end
            end
            ST_TRL_LO: begin
               if (accept_c) begin
                  crc_ok  <= ({trl_hi, s_data} == crc_out);
                  s_ready <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state   <= ST_IDLE;
               s_ready <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef CRC_ERRCNT_EN
   // Saturating count of failed frames; clear wins over increment.
   always_ff @(posedge clck or negedge rstn) begin
      if (!rstn) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if ((state == ST_DONE) && !crc_ok && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/crc_frame_ctrl.md
Name: crc_frame_ctrl

Overview:
Receive-side sequencer for the serial CRC-16 shift engine. It accepts a frame of LEN payload bytes followed by a 2-byte CRC trailer over a valid/ready byte stream. It serialises each payload byte MSB-first into the bit engine, then compares the trailer against the computed CRC. It sits between the byte deframer and the packet-accept logic, and reports crc_ok/done per frame.

Parameters:
LEN_W, 8, width of frame length (max payload 2^LEN_W-1 bytes)
POLY, 16'h8005, generator taps (x^16+x^15+x^2+1), non-reflected
INIT, 16'hFFFF, CRC register preset at frame start; no final XOR

Ports:
clck  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin new frame (sampled only in IDLE)
len  in  LEN_W  payload byte count, latched on accepted start
s_data  in  8  incoming byte (payload, then CRC hi, then CRC lo)
s_valid  in  1  s_data valid
s_ready  out  1  controller can take a byte this cycle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse: frame check complete
crc_ok  out  1  result of last frame, held until next accepted start
crc_out  out  16  computed CRC of last frame payload, held

Behaviour:
- Reset (rstn=0, async): state IDLE; s_ready=0, busy=0, done=0, crc_ok=0, crc_out=16'h0000, engine=INIT, byte/bit counters 0.
- FSM states: IDLE, LOAD, SHIFT, TRL_HI, TRL_LO, DONE.
- IDLE: start=1 -> latch len, preset engine to INIT, crc_ok=0, busy=1. Next state is TRL_HI if len==0, else LOAD.
- LOAD: s_ready=1. On s_valid&&s_ready -> latch byte, bit_cnt=7, go to SHIFT.
- SHIFT: s_ready=0. Each cycle feed shift_reg[bit_cnt] to the engine (MSB first) and decrement bit_cnt. After the bit-0 cycle, byte_cnt++. Then go to LOAD if byte_cnt<len, else TRL_HI.
- Throughput: 9 cycles/byte minimum (1 accept + 8 shift).
- Engine bit step, per enabled cycle: fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0).
- Entry to TRL_HI: crc_out <= engine CRC (payload-only CRC).
- TRL_HI: s_ready=1. On accept, latch the received high byte and go to TRL_LO.
- TRL_LO: s_ready=1. On accept, crc_ok <= ({hi,s_data}==crc_out) and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Minimum frame latency: start -> done = 1 + 9*len + 2 + 1 cycles, with s_valid held high.
- start while busy: ignored, with no effect on the frame in flight.
- start in the DONE cycle: ignored; accepted from IDLE only.
- s_valid without a frame in progress: bytes not consumed (s_ready=0 in IDLE/SHIFT/DONE).
- s_valid low during LOAD/TRL_*: controller waits indefinitely with no timeout and holds all state.
- rstn asserted mid-frame: immediate return to reset values; partial frame discarded, no done pulse.
- len == maximum (2^LEN_W-1): byte_cnt is LEN_W wide, compare byte_cnt<len, no wrap.

Optional Feature:
Macro CRC_ERRCNT_EN.
- Defined: adds output err_cnt [15:0], reset 0, incremented in the DONE cycle when crc_ok==0. Saturates at 16'hFFFF. Also adds input err_clr: synchronous clear to 0, with clear taking priority over increment in the same cycle.
- Undefined: neither port exists, and no counter logic is built.

Decomposition:
- Package crc_pkg: FSM state enum, CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF, CRC16_CHECK=16'hAEE7 (check value for "123456789").
- One sub-module crc16_bit_engine, with ports clck, rstn, init, en, bit_in, crc[15:0]. It implements the bit step; init has priority over en.
- crc_frame_ctrl holds the FSM, counters, byte latch, trailer compare and the optional counter.

Test Plan:
- Frame "123456789" (len=9) + trailer 0xAE,0xE7, s_valid always high -> done after 1+81+2+1 cycles, crc_out=16'hAEE7, crc_ok=1.
- Same payload, trailer 0xAE,0xE6 -> crc_out=16'hAEE7, crc_ok=0. With CRC_ERRCNT_EN, err_cnt goes 0->1; err_clr with a failing done in the same cycle -> err_cnt=0.
- len=0, trailer 0xFF,0xFF -> no payload bytes consumed, crc_out=16'hFFFF, crc_ok=1, done 4 cycles after start.
- Payload "123456789" with s_valid dropped 5 cycles before bytes 3 and 7 -> same result crc_out=16'hAEE7, crc_ok=1. s_ready low throughout SHIFT.
- start pulsed while busy during byte 4 -> ignored, frame result unchanged. rstn low during byte 5 -> all outputs reset, no done. A new frame then passes with crc_ok=1.
